// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-string to signed binary converter.
// Horner evaluation, one nibble per clock, most-significant nibble first.
// Nibbles 0-9 are digits, 0xE is a minus sign, all other codes are blanks.
// Optional macro BCDTOBIN_SAT_EN: saturate bin_out on overflow instead of wrapping.
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned OUT_W  = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGITS*4-1:0]     bcd_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] bin_out,
  output logic                    ovf
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned NXT_W = OUT_W + 5;
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_MAG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t               state_q, state_d;
  logic [DIGITS*4-1:0]  bcd_q, bcd_d;
  logic [OUT_W-1:0]     mag_q, mag_d;
  logic                 neg_q, neg_d;
  logic                 ovf_stk_q, ovf_stk_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_W-1:0]     bin_q, bin_d;
  logic                 ovf_q, ovf_d;

  logic [3:0]           nib;
  logic [3:0]           digit;
  logic [NXT_W-1:0]     nxt;
  logic [OUT_W-1:0]     mag_step;
  logic                 neg_step;
  logic                 stk_step;
  logic                 fin_ovf;
  logic [OUT_W-1:0]     fin_bin;

  // Horner step on the current nibble plus the result the last step would produce.
  // The result uses the post-step mag/neg/ovf_stk so the final nibble is included.
  always_comb begin
    nib = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) nib = bcd_q[4*i +: 4];
    end
    digit    = (nib <= 4'd9) ? nib : 4'd0;
    nxt      = NXT_W'(mag_q) * NXT_W'(10) + NXT_W'(digit);
    mag_step = nxt[OUT_W-1:0];
    stk_step = ovf_stk_q | (nxt >= (NXT_W'(1) << OUT_W));
    neg_step = neg_q | (nib == 4'hE);
    fin_ovf  = stk_step | (!neg_step && (mag_step > MAX_POS))
                        | (neg_step && (mag_step > MIN_MAG));
    fin_bin  = neg_step ? (OUT_W'(0) - mag_step) : mag_step;
`ifdef BCDTOBIN_SAT_EN
    if (fin_ovf) fin_bin = neg_step ? MIN_MAG : MAX_POS;
`else
`endif
  end

  // Next-state and registered-output logic for the IDLE/CONV/DONE sequence.
  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    ovf_stk_d   = ovf_stk_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    bin_d       = bin_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          bcd_d      = bcd_in;
          mag_d      = '0;
          neg_d      = 1'b0;
          ovf_stk_d  = 1'b0;
          idx_d      = IDX_W'(DIGITS - 1);
          in_ready_d = 1'b0;
          state_d    = CONV;
        end
      end
      CONV: begin
        mag_d     = mag_step;
        neg_d     = neg_step;
        ovf_stk_d = stk_step;
        if (idx_q == '0) begin
          bin_d       = fin_bin;
          ovf_d       = fin_ovf;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      ovf_stk_q   <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      ovf_stk_q   <= ovf_stk_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      bin_q       <= bin_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Testbench for bcd_to_bin_seq: directed cases from the datasheet plus random
// strings checked against a digit-sum reference model.
module tb_bcd_to_bin_seq;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned OUT_W  = 11;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [DIGITS*4-1:0]     bcd_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] bin_out;
  logic                    ovf;

  int tests;
  int fails;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bcd_in(bcd_in), .out_valid(out_valid), .out_ready(out_ready),
    .bin_out(bin_out), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: value is the plain weighted digit sum; sign from any 0xE nibble.
  task automatic model(input logic [DIGITS*4-1:0] s,
                       output logic signed [OUT_W-1:0] eb, output logic eo);
    longint total, w, v, lim;
    logic neg;
    logic [3:0] n;
    total = 0; w = 1; neg = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      n = s[4*i +: 4];
      if (n <= 4'd9) total += longint'(n) * w;
      if (n == 4'hE) neg = 1'b1;
      w *= 10;
    end
    lim = longint'(1) << (OUT_W - 1);
    eo  = neg ? (total > lim) : (total > lim - 1);
    v   = neg ? -total : total;
`ifdef BCDTOBIN_SAT_EN
    if (eo) v = neg ? -lim : lim - 1;
`endif
    eb = OUT_W'(v);
  endtask

  // One conversion: accept, measure latency, check result, optional back-pressure.
  task automatic convert(input logic [DIGITS*4-1:0] s, input int hold,
                         input logic noise, input logic early_ready);
    logic signed [OUT_W-1:0] eb, held;
    logic eo;
    int lat;
    model(s, eb, eo);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    bcd_in = s; in_valid = 1'b1; out_ready = early_ready;
    @(posedge clk); #1;
    if (noise) bcd_in = DIGITS*4'($urandom);
    else in_valid = 1'b0;
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < int'(DIGITS) + 6) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(DIGITS));
    check("bin_out", 32'(bin_out), 32'(eb));
    check("ovf", 32'(ovf), 32'(eo));
    check("in_ready_done", 32'(in_ready), 32'd0);
    held = bin_out;
    for (int j = 0; j < hold; j++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_bin", 32'(bin_out), 32'(held));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_bin", 32'(bin_out), 32'(held));
  endtask

  function automatic logic [DIGITS*4-1:0] rand_bcd();
    logic [DIGITS*4-1:0] s;
    int r;
    s = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) s[4*i +: 4] = 4'($urandom_range(0, 9));
      else       s[4*i +: 4] = 4'($urandom_range(10, 15));
    end
    return s;
  endfunction

  initial begin
    logic [DIGITS*4-1:0] dir [7];
    tests = 0; fails = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bcd_in = '0;
    dir = '{16'h0999, 16'hE123, 16'hFF42, 16'hE000, 16'hE024, 16'h1024, 16'h9999};

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bin", 32'(bin_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (dir[i]) convert(dir[i], (i == 0) ? 5 : 0, 1'b0, 1'b0);

    // Busy-time in_valid and early out_ready must not disturb a conversion.
    convert(16'hE321, 0, 1'b1, 1'b0);
    convert(16'h0512, 0, 1'b0, 1'b1);

    // Reset mid-conversion discards the in-flight result.
    bcd_in = 16'h0777; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_bin", 32'(bin_out), 32'd0);
    for (int j = 0; j < int'(DIGITS) + 2; j++) begin
      @(posedge clk); #1;
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end

    for (int k = 0; k < 40; k++) convert(rand_bcd(), k % 3, k[2], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
